// File: rtl/dmem_arbiter_if.sv
// Shared data-memory arbiter bus: two requester ports plus the memory-side
// read/write channel. The arbiter takes the slave view; the requesters and
// the memory model together take the master view.
interface dmem_arbiter_if;
   // requester port 0 (load/store unit) and port 1 (DMA/debug)
   logic        req0, req1;
   logic        wr0, wr1;
   logic [31:0] addr0, addr1;
   logic [31:0] wdata0, wdata1;
   logic        ack0, ack1;
   logic        err0, err1;
   logic [31:0] rdata0, rdata1;
   logic        busy;

   // memory side
   logic        re, we;
   logic [31:0] Ra, Wa, Din;
   logic [31:0] Dout;

   modport slave (
      input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, Dout,
      output ack0, ack1, err0, err1, rdata0, rdata1, busy,
             re, we, Ra, Wa, Din
   );

   modport master (
      output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, Dout,
      input  ack0, ack1, err0, err1, rdata0, rdata1, busy,
             re, we, Ra, Wa, Din
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// One transaction in flight at a time; each one takes IDLE -> ACCESS -> RESP.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | waiting; on any req, pick a winner and latch its wr/addr/wdata
//   ACCESS | drive the memory for one cycle; capture read data / range error
//   RESP   | one-cycle ack (and err) to the winner; record it as last grant
module dmem_arbiter #(
   parameter int unsigned DEPTH    = 4500,
   parameter int unsigned P0_FIRST = 1
) (
   input logic           C,
   input logic           R,
   dmem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [31:0] DEPTH_W    = 32'(DEPTH);
   localparam logic        FIRST_PORT = (P0_FIRST != 0) ? 1'b0 : 1'b1;

   state_t      state_q, state_d;
   logic        win_q, win_d;
   logic        wr_q, wr_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        last_q, last_d;
   logic        last_vld_q, last_vld_d;
   logic [31:0] rdata0_q, rdata0_d;
   logic [31:0] rdata1_q, rdata1_d;
   logic        err_q, err_d;

   logic        in_range;
   logic [31:0] rd_val;

   // unsigned 32-bit compare, so huge addresses are out of range too
   assign in_range = (addr_q < DEPTH_W);

   // next-state, arbitration and capture logic
   always_comb begin
      state_d    = state_q;
      win_d      = win_q;
      wr_d       = wr_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      last_d     = last_q;
      last_vld_d = last_vld_q;
      rdata0_d   = rdata0_q;
      rdata1_d   = rdata1_q;
      err_d      = err_q;
      rd_val     = in_range ? bus.Dout : 32'h0;

      case (state_q)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               // contention goes to the port not served last; before any
               // grant has happened the configured port is favoured
               if (bus.req0 && bus.req1) begin
                  win_d = last_vld_q ? ~last_q : FIRST_PORT;
               end else begin
                  win_d = bus.req1;
               end
               wr_d    = win_d ? bus.wr1    : bus.wr0;
               addr_d  = win_d ? bus.addr1  : bus.addr0;
               wdata_d = win_d ? bus.wdata1 : bus.wdata0;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            err_d = !in_range;
            // reads load the winner's register; an out-of-range access
            // forces it to zero; in-range writes leave it alone
            if (!wr_q || !in_range) begin
               if (win_q) begin
                  rdata1_d = rd_val;
               end else begin
                  rdata0_d = rd_val;
               end
            end
            state_d = RESP;
         end
         RESP: begin
            last_d     = win_q;
            last_vld_d = 1'b1;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // state registers with synchronous reset
   always_ff @(posedge C) begin
      if (R) begin
         state_q    <= IDLE;
         win_q      <= 1'b0;
         wr_q       <= 1'b0;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         last_q     <= 1'b0;
         last_vld_q <= 1'b0;
         rdata0_q   <= 32'h0;
         rdata1_q   <= 32'h0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         win_q      <= win_d;
         wr_q       <= wr_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         last_q     <= last_d;
         last_vld_q <= last_vld_d;
         rdata0_q   <= rdata0_d;
         rdata1_q   <= rdata1_d;
         err_q      <= err_d;
      end
   end

   // Enables are gated by R so a reset landing mid-ACCESS kills the access
   // before the memory commits it.
   assign bus.re     = (state_q == ACCESS) && in_range && !wr_q && !R;
   assign bus.we     = (state_q == ACCESS) && in_range &&  wr_q && !R;
   assign bus.Ra     = addr_q;
   assign bus.Wa     = addr_q;
   assign bus.Din    = wdata_q;

   assign bus.busy   = (state_q == ACCESS) || (state_q == RESP);
   assign bus.ack0   = (state_q == RESP) && !win_q;
   assign bus.ack1   = (state_q == RESP) &&  win_q;
   assign bus.err0   = bus.ack0 && err_q;
   assign bus.err1   = bus.ack1 && err_q;
   assign bus.rdata0 = rdata0_q;
   assign bus.rdata1 = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a transaction-level model timed by edge count,
// a per-cycle compare process, and directed scenarios with literal checks.
module tb_dmem_arbiter;
   localparam int DEPTH = 4500;

   logic C = 1'b0;
   logic R = 1'b1;

   dmem_arbiter_if bus();

   dmem_arbiter #(.DEPTH(DEPTH), .P0_FIRST(1)) dut (
      .C   (C),
      .R   (R),
      .bus (bus)
   );

   always #5 C = ~C;

   // memory attached to the DUT (garbage when not enabled)
   logic [31:0] mem [0:DEPTH-1];
   assign bus.Dout = (bus.re && (bus.Ra < 32'(DEPTH))) ? mem[bus.Ra[12:0]] : 32'hCAFE_F00D;
   always @(posedge C) begin
      if (bus.we) mem[bus.Wa[12:0]] <= bus.Din;
   end

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- model ----------------
   // t_g is the edge number at which the current transaction was granted;
   // the access phase is the cycle after t_g, the response the cycle after
   // t_g+1, and the next grant may happen at edge t_g+3 at the earliest.
   int          t_g       = -10;
   int          g_port    = 0;
   logic        g_wr      = 1'b0;
   logic [31:0] g_addr    = 32'h0;
   logic [31:0] g_wdata   = 32'h0;
   int          last_port = 0;
   bit          last_vld  = 1'b0;
   logic [31:0] rd_m [2];
   logic [31:0] mm [0:DEPTH-1];
   bit          model_on  = 1'b0;

   always @(posedge C) begin
      cyc++;
      if (R) begin
         t_g = -10; last_vld = 1'b0; last_port = 0;
         rd_m[0] = 32'h0; rd_m[1] = 32'h0;
         g_port = 0; g_wr = 1'b0; g_addr = 32'h0; g_wdata = 32'h0;
         model_on = 1'b1;
      end else begin
         if (cyc == t_g + 1) begin
            if (g_addr >= 32'(DEPTH)) rd_m[g_port] = 32'h0;
            else if (g_wr)            mm[g_addr[12:0]] = g_wdata;
            else                      rd_m[g_port] = mm[g_addr[12:0]];
         end
         if (cyc == t_g + 2) begin
            last_vld  = 1'b1;
            last_port = g_port;
         end
         if (cyc >= t_g + 3 && (bus.req0 || bus.req1)) begin
            if (bus.req0 && bus.req1) g_port = last_vld ? 1 - last_port : 0;
            else                      g_port = bus.req1 ? 1 : 0;
            g_wr    = (g_port == 1) ? bus.wr1    : bus.wr0;
            g_addr  = (g_port == 1) ? bus.addr1  : bus.addr0;
            g_wdata = (g_port == 1) ? bus.wdata1 : bus.wdata0;
            t_g     = cyc;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   int          ack_port_q[$];
   int          ack_cyc_q[$];
   int          we_cnt = 0;
   int          re_cnt = 0;
   logic [31:0] we_wa  = 32'h0;

   initial begin : cmp
      int   ph;
      logic in_r;
      forever begin
         @(posedge C);
         #1;
         if (model_on) begin
            ph   = cyc - t_g;
            in_r = (g_addr < 32'(DEPTH));
            chk("busy",   bus.busy,   (ph == 0 || ph == 1));
            chk("re",     bus.re,     (ph == 0) && in_r && !g_wr && !R);
            chk("we",     bus.we,     (ph == 0) && in_r &&  g_wr && !R);
            chk("ack0",   bus.ack0,   (ph == 1) && (g_port == 0));
            chk("ack1",   bus.ack1,   (ph == 1) && (g_port == 1));
            chk("err0",   bus.err0,   (ph == 1) && (g_port == 0) && !in_r);
            chk("err1",   bus.err1,   (ph == 1) && (g_port == 1) && !in_r);
            chk("rdata0", bus.rdata0, rd_m[0]);
            chk("rdata1", bus.rdata1, rd_m[1]);
            chk("Ra",     bus.Ra,     g_addr);
            chk("Wa",     bus.Wa,     g_addr);
            chk("Din",    bus.Din,    g_wdata);
         end
         if (bus.ack0 === 1'b1) begin ack_port_q.push_back(0); ack_cyc_q.push_back(cyc); end
         if (bus.ack1 === 1'b1) begin ack_port_q.push_back(1); ack_cyc_q.push_back(cyc); end
         if (bus.we === 1'b1)   begin we_cnt++; we_wa = bus.Wa; end
         if (bus.re === 1'b1)   re_cnt++;
      end
   end

   // ---------------- stimulus ----------------
   // Called at a falling edge; raises req on port p, waits for its ack and
   // drops req on the falling edge inside the response cycle.
   task automatic txn(input int p, input logic w, input logic [31:0] a,
                      input logic [31:0] d, output int ack_at);
      bit got;
      got    = 1'b0;
      ack_at = -1;
      if (p == 0) begin bus.req0 = 1'b1; bus.wr0 = w; bus.addr0 = a; bus.wdata0 = d; end
      else        begin bus.req1 = 1'b1; bus.wr1 = w; bus.addr1 = a; bus.wdata1 = d; end
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge C);
         #1;
         if (((p == 0) ? bus.ack0 : bus.ack1) === 1'b1) begin
            got    = 1'b1;
            ack_at = cyc;
         end
      end
      chk("ack_seen", got, 1'b1);
      @(negedge C);
      if (p == 0) bus.req0 = 1'b0;
      else        bus.req1 = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: run did not reach its end by time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int at, k0, wb, rb, base, n, first;
      bit got;
      for (int i = 0; i < DEPTH; i++) begin
         mem[i] = 32'h0;
         mm[i]  = 32'h0;
      end
      mem[5] = 32'h5555_0005; mm[5] = 32'h5555_0005;
      mem[7] = 32'h0000_0777; mm[7] = 32'h0000_0777;
      bus.req0 = 1'b0; bus.wr0 = 1'b0; bus.addr0 = 32'h0; bus.wdata0 = 32'h0;
      bus.req1 = 1'b0; bus.wr1 = 1'b0; bus.addr1 = 32'h0; bus.wdata1 = 32'h0;

      R = 1'b1;
      repeat (2) @(posedge C);
      @(negedge C);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_ack0", bus.ack0, 1'b0);
      chk("rst_ack1", bus.ack1, 1'b0);
      chk("rst_Ra",   bus.Ra,   32'h0);
      chk("rst_Din",  bus.Din,  32'h0);

      // lone port-1 read right out of reset
      R  = 1'b0;
      k0 = cyc;
      txn(1, 1'b0, 32'd7, 32'h0, at);
      chk("p1_first_latency", at - k0, 2);
      chk("p1_first_rdata",   bus.rdata1, 32'h0000_0777);

      // port-0 write then read-back of addr 10
      wb = we_cnt;
      txn(0, 1'b1, 32'd10, 32'hDEAD_BEEF, at);
      chk("wr10_we_pulses", we_cnt - wb, 1);
      chk("wr10_Wa",        we_wa, 32'd10);
      chk("wr10_mem",       mem[10], 32'hDEAD_BEEF);
      txn(0, 1'b0, 32'd10, 32'h0, at);
      chk("rd10_ack0",   bus.ack0,   1'b1);
      chk("rd10_err0",   bus.err0,   1'b0);
      chk("rd10_rdata0", bus.rdata0, 32'hDEAD_BEEF);

      // port-0 write, then port-1 read of the same word
      txn(0, 1'b1, 32'd20, 32'h1234_5678, at);
      txn(1, 1'b0, 32'd20, 32'h0, at);
      chk("xport_rdata1", bus.rdata1, 32'h1234_5678);
      chk("xport_rdata0", bus.rdata0, 32'hDEAD_BEEF);

      // range boundary on port 1
      txn(0, 1'b1, 32'd4499, 32'hA5A5_0001, at);
      rb = re_cnt;
      txn(1, 1'b0, 32'd4500, 32'h0, at);
      chk("oor_re_pulses", re_cnt - rb, 0);
      chk("oor_err1",      bus.err1,   1'b1);
      chk("oor_rdata1",    bus.rdata1, 32'h0);
      txn(1, 1'b0, 32'd4499, 32'h0, at);
      chk("edge_err1",     bus.err1,   1'b0);
      chk("edge_rdata1",   bus.rdata1, 32'hA5A5_0001);
      txn(1, 1'b0, 32'hFFFF_FFFF, 32'h0, at);
      chk("max_err1",      bus.err1,   1'b1);

      // both ports requesting continuously for 12 edges
      base = ack_port_q.size();
      bus.req0 = 1'b1; bus.wr0 = 1'b0; bus.addr0 = 32'd10;
      bus.req1 = 1'b1; bus.wr1 = 1'b0; bus.addr1 = 32'd20;
      repeat (12) @(posedge C);
      @(negedge C);
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      repeat (3) @(negedge C);
      n = ack_port_q.size() - base;
      chk("rr_ack_count", n, 4);
      for (int j = 0; j < 4; j++) begin
         if (j < n) chk("rr_ack_port", ack_port_q[base + j], j % 2);
         if (j > 0 && j < n) chk("rr_ack_gap", ack_cyc_q[base + j] - ack_cyc_q[base + j - 1], 3);
      end

      // reset during the access cycle of a write to addr 5
      bus.req0 = 1'b1; bus.wr0 = 1'b1; bus.addr0 = 32'd5; bus.wdata0 = 32'hBAD0_0005;
      @(posedge C);
      #1;
      chk("abort_we_before_R", bus.we, 1'b1);
      @(negedge C);
      R = 1'b1;
      bus.req0 = 1'b0;
      #1;
      chk("abort_we_gated", bus.we, 1'b0);
      @(posedge C);
      #1;
      chk("abort_ack0",   bus.ack0,   1'b0);
      chk("abort_busy",   bus.busy,   1'b0);
      chk("abort_Ra",     bus.Ra,     32'h0);
      chk("abort_Din",    bus.Din,    32'h0);
      chk("abort_rdata0", bus.rdata0, 32'h0);
      chk("abort_mem5",   mem[5],     32'h5555_0005);
      @(negedge C);
      R = 1'b0;

      // simultaneous requests after reset: port 0 is favoured
      bus.req0 = 1'b1; bus.wr0 = 1'b0; bus.addr0 = 32'd5;
      bus.req1 = 1'b1; bus.wr1 = 1'b0; bus.addr1 = 32'd10;
      got   = 1'b0;
      first = -1;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge C);
         #1;
         if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) begin
            got   = 1'b1;
            first = (bus.ack1 === 1'b1) ? 1 : 0;
         end
      end
      chk("post_rst_first", first, 0);
      @(negedge C);
      bus.req0 = 1'b0;
      txn(1, 1'b0, 32'd10, 32'h0, at);
      chk("post_rst_rdata0", bus.rdata0, 32'h5555_0005);
      chk("post_rst_rdata1", bus.rdata1, 32'hDEAD_BEEF);

      repeat (2) @(negedge C);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
